pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: consecutive stallreq_mem cycles before stall_timeout sets.
REQ-002 SHALL have parameter CNT_W, default 16: width of perf_stall_cnt.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 stallreq_if  input  1  instruction fetch miss; level, held until serviced.
REQ-006 stallreq_id  input  1  load-use hazard.
REQ-007 stallreq_ex  input  1  multi-cycle EX op (mul/div) busy.
REQ-008 stallreq_mem  input  1  data memory access outstanding.
REQ-009 flush_req  input  1  exception/eret flush request; level, held until flush seen.
REQ-010 flush_pc_i  input  32  redirect target, sampled on flush acceptance.
REQ-011 stall  output  Stall_t  fields stall_if, stall_id, stall_ex, stall_mem, stall_wb.
REQ-012 flush  output  1  one-cycle pipeline flush pulse; also serves as flush_req acknowledge.
REQ-013 flush_pc_o  output  32  redirect target; valid when flush=1, else 0.
REQ-014 stall_timeout  output  1  sticky watchdog flag.
REQ-015 perf_stall_cnt  output  CNT_W  saturating count of cycles with stall.stall_if=1.

Function
REQ-016 stall SHALL be combinational from requests and state; highest active priority wins: mem > ex > id > if.
REQ-017 stallreq_mem SHALL drive stall_if..stall_mem=1, stall_wb=0 (MEM/WB bubble insertion).
REQ-018 stallreq_ex (no mem) SHALL drive stall_if..stall_ex=1, stall_mem=stall_wb=0.
REQ-019 stallreq_id (no mem/ex) SHALL drive stall_if=stall_id=1, rest 0.
REQ-020 stallreq_if alone SHALL drive stall_if=1 only; no request: all fields 0.
REQ-021 FSM SHALL have states IDLE, PEND, FLUSH.
REQ-022 IDLE: flush_req=1 and stallreq_mem=0 -> FLUSH, latch flush_pc_i; flush_req=1 and stallreq_mem=1 -> PEND, latch flush_pc_i; else stay.
REQ-023 PEND: stalls driven per REQ-016..020; flush_req/flush_pc_i changes ignored; stallreq_mem=0 -> FLUSH.
REQ-024 FLUSH: lasts exactly one cycle; flush=1, flush_pc_o=latched pc, all stall fields 0 regardless of requests; -> IDLE.
REQ-025 flush_req SHALL be ignored in FLUSH; if still high back in IDLE it is re-accepted per REQ-022.
REQ-026 Acceptance latency: flush_req sampled at edge N with stallreq_mem=0 -> flush=1 during cycle N+1.
REQ-027 Watchdog counter SHALL increment each cycle stallreq_mem=1, clear when 0; on reaching TIMEOUT, stall_timeout SHALL set and stay set until reset; counter saturates.
REQ-028 perf_stall_cnt SHALL increment when stall.stall_if=1, saturate at all-ones, never wrap.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, flush=0, flush_pc_o=0, latched pc=0, stall_timeout=0, watchdog=0, perf_stall_cnt=0.
REQ-030 Reset asserted in PEND or FLUSH SHALL abandon the pending flush; no flush pulse after release.
REQ-031 stall during reset SHALL follow requests combinationally (state IDLE).

Verification
REQ-032 Priority: stallreq_if=stallreq_ex=1 -> stall={if,id,ex}=1, mem=wb=0; add stallreq_mem -> mem=1, wb=0.
REQ-033 Direct flush: flush_req=1, flush_pc_i=0xBFC00380, no stalls, edge N -> flush=1, flush_pc_o=0xBFC00380 in cycle N+1 only, stall all 0 with stallreq_ex=1.
REQ-034 Deferred flush: flush_req with stallreq_mem=1 for 5 cycles, flush_pc_i changed to 0x0 mid-wait -> single flush pulse cycle after stallreq_mem drops, flush_pc_o=original pc.
REQ-035 Held request: flush_req held 3 cycles -> two flush pulses separated by one IDLE cycle.
REQ-036 Watchdog: TIMEOUT=8, stallreq_mem high 7 cycles, low 1, high 8 -> stall_timeout rises only after 8th consecutive cycle, stays 1 after drop.
REQ-037 Reset mid-PEND: rst low one cycle during PEND -> all outputs 0, no flush after release; CNT_W=4 with stallreq_if held 20 cycles -> perf_stall_cnt=15.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline stall/flush controller for a 5-stage core.
//
// Stall vector is combinational from the stall requests (priority
// mem > ex > id > if); a flush request is accepted in IDLE, deferred while a
// data memory access is outstanding, and emitted as a single-cycle flush
// pulse carrying the redirect PC captured at acceptance.
// Also provides a sticky watchdog on consecutive stallreq_mem cycles and a
// saturating count of fetch-stall cycles.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous reset, active low
//   stallreq_if    in   instruction fetch miss
//   stallreq_id    in   load-use hazard
//   stallreq_ex    in   multi-cycle EX op busy
//   stallreq_mem   in   data memory access outstanding
//   flush_req      in   exception/eret flush request (level)
//   flush_pc_i     in   redirect target, captured on acceptance
//   stall          out  per-stage stall fields
//   flush          out  one-cycle flush pulse / flush_req acknowledge
//   flush_pc_o     out  redirect target while flush=1, else 0
//   stall_timeout  out  sticky watchdog flag
//   perf_stall_cnt out  saturating count of stall_if cycles

package pipeline_ctrl_pkg;
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic stall_wb;
  } Stall_t;
endpackage

// state | meaning
// IDLE  | no flush in progress; flush_req may be accepted
// PEND  | flush accepted, waiting for stallreq_mem to drop
// FLUSH | flush pulse cycle; all stalls forced off
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc_i,
  output Stall_t            stall,
  output logic              flush,
  output logic [31:0]       flush_pc_o,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc_q;
  logic            latch_pc;
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    latch_pc   = 1'b0;
    stall      = '0;
    flush      = 1'b0;
    flush_pc_o = '0;

    if (stallreq_mem) begin
      stall = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1, stall_mem: 1'b1, stall_wb: 1'b0};
    end else if (stallreq_ex) begin
      stall = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b1, stall_mem: 1'b0, stall_wb: 1'b0};
    end else if (stallreq_id) begin
      stall = '{stall_if: 1'b1, stall_id: 1'b1, stall_ex: 1'b0, stall_mem: 1'b0, stall_wb: 1'b0};
    end else if (stallreq_if) begin
      stall = '{stall_if: 1'b1, stall_id: 1'b0, stall_ex: 1'b0, stall_mem: 1'b0, stall_wb: 1'b0};
    end

    case (state)
      IDLE: begin
        if (flush_req) begin
          latch_pc  = 1'b1;
          state_nxt = stallreq_mem ? PEND : FLUSH;
        end
      end
      PEND: begin
        // The target was captured at acceptance; later flush_pc_i changes are ignored.
        if (!stallreq_mem) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // Flush overrides every stall; the redirected pipeline restarts clean.
        stall      = '0;
        flush      = 1'b1;
        flush_pc_o = pc_q;
        state_nxt  = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= '0;
    end else if (latch_pc) begin
      pc_q <= flush_pc_i;
    end
  end

  // Watchdog: counts consecutive stallreq_mem cycles, saturating at TIMEOUT.
  // The flag is set on the same edge the count reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      if (!stallreq_mem) begin
        wd_cnt <= '0;
      end else if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (stallreq_mem && (wd_cnt == WD_LAST)) begin
        stall_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
    end else if (stall.stall_if && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
    end
  end

endmodule
